// File: rtl/ext_mem_host_if.sv
// rtl/ext_mem_host_if.sv - command/response byte streams and external memory port bundle
interface ext_mem_host_if;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        enable;
  logic        busy;
  logic [31:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;
  logic [31:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [31:0] wdata_ext_2;
  logic [31:0] rdata_ext_2;

  modport master (
    input  rx_valid, rx_data, tx_ready, rdata_ext, rdata_ext_2,
    output rx_ready, tx_valid, tx_data, enable, busy,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, rdata_ext, rdata_ext_2,
    input  rx_ready, tx_valid, tx_data, enable, busy,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/ext_mem_host.sv
// rtl/ext_mem_host.sv - byte-command host that loads imem/dmem, runs the CPU and dumps dmem
module ext_mem_host #(
  parameter int ADDR_STRIDE = 4,
  parameter int RD_LAT      = 1
) (
  input logic            clk,
  input logic            arst_n,
  ext_mem_host_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, RUN, RD_REQ, RD_WAIT, SEND, ACK, ERR
  } state_t;
  typedef enum logic [1:0] {OP_IMEM, OP_DMEM, OP_RUN, OP_DUMP} op_t;

  localparam logic [31:0] STRIDE   = 32'(ADDR_STRIDE);
  localparam logic [1:0]  LAT_LAST = 2'(RD_LAT - 1);

  state_t      state, state_nx;
  op_t         op, op_nx;
  logic [15:0] len, len_nx, idx, idx_nx, idx_inc, len_rx;
  logic [1:0]  bcnt, bcnt_nx, lat, lat_nx;
  logic [31:0] word, word_nx, word_rx, idx_addr, inc_addr;
  logic [31:0] addr_i, addr_i_nx, wdata_i, wdata_i_nx;
  logic [31:0] addr_d, addr_d_nx, wdata_d, wdata_d_nx;
  logic        rx_fire, tx_fire;
  logic        unused_rdata;

  assign unused_rdata = ^bus.rdata_ext;

  assign idx_inc  = idx + 16'd1;
  assign idx_addr = {16'b0, idx} * STRIDE;
  assign inc_addr = {16'b0, idx_inc} * STRIDE;
  assign len_rx   = {len[15:8], bus.rx_data};
  assign word_rx  = {word[23:0], bus.rx_data};
  assign rx_fire  = bus.rx_valid & bus.rx_ready;
  assign tx_fire  = bus.tx_valid & bus.tx_ready;

  // rx_ready is gated by reset so every output reads 0 while arst_n is low
  assign bus.rx_ready    = arst_n & (state inside {IDLE, LEN_HI, LEN_LO, DATA});
  assign bus.tx_valid    = state inside {SEND, ACK, ERR};
  assign bus.tx_data     = (state == SEND) ? word[31:24] :
                           (state == ACK)  ? 8'hA5 :
                           (state == ERR)  ? 8'hEE : 8'h00;
  assign bus.enable      = (state == RUN);
  assign bus.busy        = (state != IDLE);
  assign bus.wen_ext     = (state == WRITE) && (op == OP_IMEM);
  assign bus.ren_ext     = 1'b0;
  assign bus.addr_ext    = addr_i;
  assign bus.wdata_ext   = wdata_i;
  assign bus.wen_ext_2   = (state == WRITE) && (op == OP_DMEM);
  assign bus.ren_ext_2   = (state == RD_REQ);
  assign bus.addr_ext_2  = addr_d;
  assign bus.wdata_ext_2 = wdata_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= IDLE;
      op      <= OP_IMEM;
      len     <= '0;
      idx     <= '0;
      bcnt    <= '0;
      lat     <= '0;
      word    <= '0;
      addr_i  <= '0;
      wdata_i <= '0;
      addr_d  <= '0;
      wdata_d <= '0;
    end else begin
      state   <= state_nx;
      op      <= op_nx;
      len     <= len_nx;
      idx     <= idx_nx;
      bcnt    <= bcnt_nx;
      lat     <= lat_nx;
      word    <= word_nx;
      addr_i  <= addr_i_nx;
      wdata_i <= wdata_i_nx;
      addr_d  <= addr_d_nx;
      wdata_d <= wdata_d_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    op_nx      = op;
    len_nx     = len;
    idx_nx     = idx;
    bcnt_nx    = bcnt;
    lat_nx     = lat;
    word_nx    = word;
    addr_i_nx  = addr_i;
    wdata_i_nx = wdata_i;
    addr_d_nx  = addr_d;
    wdata_d_nx = wdata_d;
    case (state)
      IDLE: if (rx_fire) begin
        state_nx = LEN_HI;
        case (bus.rx_data)
          8'h01:   op_nx = OP_IMEM;
          8'h02:   op_nx = OP_DMEM;
          8'h03:   op_nx = OP_RUN;
          8'h04:   op_nx = OP_DUMP;
          default: state_nx = ERR;
        endcase
      end
      LEN_HI: if (rx_fire) begin
        len_nx   = {bus.rx_data, len[7:0]};
        state_nx = LEN_LO;
      end
      LEN_LO: if (rx_fire) begin
        len_nx  = len_rx;
        idx_nx  = '0;
        bcnt_nx = '0;
        if (len_rx == 16'd0) begin
          state_nx = ACK;
        end else begin
          case (op)
            OP_RUN:  state_nx = RUN;
            OP_DUMP: begin
              state_nx  = RD_REQ;
              addr_d_nx = '0;
            end
            default: state_nx = DATA;
          endcase
        end
      end
      DATA: if (rx_fire) begin
        word_nx = word_rx;
        bcnt_nx = bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          state_nx = WRITE;
          if (op == OP_IMEM) begin
            addr_i_nx  = idx_addr;
            wdata_i_nx = word_rx;
          end else begin
            addr_d_nx  = idx_addr;
            wdata_d_nx = word_rx;
          end
        end
      end
      WRITE: begin
        idx_nx   = idx_inc;
        state_nx = (idx_inc == len) ? ACK : DATA;
      end
      // len doubles as the remaining-cycle counter while running
      RUN: begin
        len_nx   = len - 16'd1;
        state_nx = (len == 16'd1) ? ACK : RUN;
      end
      RD_REQ: begin
        lat_nx   = '0;
        state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat == LAT_LAST) begin
          word_nx  = bus.rdata_ext_2;
          bcnt_nx  = '0;
          state_nx = SEND;
        end else begin
          lat_nx = lat + 2'd1;
        end
      end
      SEND: if (tx_fire) begin
        word_nx = {word[23:0], 8'h00};
        bcnt_nx = bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          idx_nx = idx_inc;
          if (idx_inc == len) begin
            state_nx = ACK;
          end else begin
            state_nx  = RD_REQ;
            addr_d_nx = inc_addr;
          end
        end
      end
      ACK, ERR: if (tx_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ext_mem_host.sv
// tb/tb_ext_mem_host.sv - randomized self-checking bench for ext_mem_host (RD_LAT 1 and 3)
module tb_ext_mem_host;
  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       sel = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b1;
  logic       bp = 1'b0;

  always #5 clk = ~clk;

  ext_mem_host_if bus1();
  ext_mem_host_if bus3();

  ext_mem_host #(.ADDR_STRIDE(4), .RD_LAT(1)) u_dut1 (.clk(clk), .arst_n(arst_n), .bus(bus1.master));
  ext_mem_host #(.ADDR_STRIDE(4), .RD_LAT(3)) u_dut3 (.clk(clk), .arst_n(arst_n), .bus(bus3.master));

  localparam logic [31:0] JUNK = 32'hBAD0_0BAD;
  logic [31:0] dmem [0:63];
  logic        req1, req3;
  logic [31:0] rq1, rq3, p1, q1, q2, q3;

  assign bus1.rx_valid    = rx_valid & ~sel;
  assign bus3.rx_valid    = rx_valid & sel;
  assign bus1.rx_data     = rx_data;
  assign bus3.rx_data     = rx_data;
  assign bus1.tx_ready    = tx_ready & ~sel;
  assign bus3.tx_ready    = tx_ready & sel;
  assign bus1.rdata_ext   = 32'h0;
  assign bus3.rdata_ext   = 32'h0;
  assign bus1.rdata_ext_2 = p1;
  assign bus3.rdata_ext_2 = q3;

  logic        m_rx_ready, m_tx_valid, m_enable, m_busy;
  logic        m_wen_ext, m_ren_ext, m_wen_ext_2, m_ren_ext_2;
  logic [7:0]  m_tx_data;
  logic [31:0] m_addr_ext, m_wdata_ext, m_addr_ext_2, m_wdata_ext_2;
  assign m_rx_ready    = sel ? bus3.rx_ready    : bus1.rx_ready;
  assign m_tx_valid    = sel ? bus3.tx_valid    : bus1.tx_valid;
  assign m_tx_data     = sel ? bus3.tx_data     : bus1.tx_data;
  assign m_enable      = sel ? bus3.enable      : bus1.enable;
  assign m_busy        = sel ? bus3.busy        : bus1.busy;
  assign m_wen_ext     = sel ? bus3.wen_ext     : bus1.wen_ext;
  assign m_ren_ext     = sel ? bus3.ren_ext     : bus1.ren_ext;
  assign m_addr_ext    = sel ? bus3.addr_ext    : bus1.addr_ext;
  assign m_wdata_ext   = sel ? bus3.wdata_ext   : bus1.wdata_ext;
  assign m_wen_ext_2   = sel ? bus3.wen_ext_2   : bus1.wen_ext_2;
  assign m_ren_ext_2   = sel ? bus3.ren_ext_2   : bus1.ren_ext_2;
  assign m_addr_ext_2  = sel ? bus3.addr_ext_2  : bus1.addr_ext_2;
  assign m_wdata_ext_2 = sel ? bus3.wdata_ext_2 : bus1.wdata_ext_2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // data memory device: read data is valid exactly RD_LAT cycles after the request
  always @(negedge clk) begin
    req1 = bus1.ren_ext_2;
    rq1  = dmem[bus1.addr_ext_2[7:2]];
    req3 = bus3.ren_ext_2;
    rq3  = dmem[bus3.addr_ext_2[7:2]];
  end
  always @(posedge clk) begin
    p1 <= req1 ? rq1 : JUNK;
    q1 <= req3 ? rq3 : JUNK;
    q2 <= q1;
    q3 <= q2;
  end

  logic [7:0]  txq[$];
  logic [63:0] iwq[$], dwq[$];
  int          enq[$];
  int          ren_cnt = 0, ren_i = 0, viol = 0, hold_err = 0, idle_cnt = 0;
  logic        stalled = 1'b0;
  logic [7:0]  held = 8'h00;

  always @(negedge clk) begin
    if (stalled && (!m_tx_valid || m_tx_data != held)) hold_err++;
    if (!bp) tx_ready = 1'b1;
    else if (idle_cnt > 0) begin
      tx_ready = 1'b0;
      idle_cnt--;
    end else tx_ready = 1'b1;
    if (m_tx_valid && tx_ready) begin
      txq.push_back(m_tx_data);
      if (bp) idle_cnt = $urandom_range(0, 5);
    end
    stalled = m_tx_valid && !tx_ready;
    held    = m_tx_data;
    if (m_enable) begin
      enq.push_back(cyc);
      if (m_wen_ext || m_wen_ext_2 || m_ren_ext_2) viol++;
    end
    if (m_wen_ext) iwq.push_back({m_addr_ext, m_wdata_ext});
    if (m_wen_ext_2) begin
      dwq.push_back({m_addr_ext_2, m_wdata_ext_2});
      dmem[m_addr_ext_2[7:2]] = m_wdata_ext_2;
    end
    if (m_ren_ext_2) ren_cnt++;
    if (m_ren_ext) ren_i++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [31:0] ref_dmem [0:63];
  logic [31:0] words[$];
  logic [7:0]  cmd[$], exp_tx[$];
  logic [63:0] exp_iw[$], exp_dw[$];
  int          exp_en = 0, exp_ren = 0, last_acc = 0, dm_hi = 0;

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!m_rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check_val("rx_accept_timeout", m_rx_ready, 1);
    last_acc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic mk_load(input bit dm);
    logic [15:0] n = 16'(words.size());
    cmd.push_back(dm ? 8'h02 : 8'h01);
    cmd.push_back(n[15:8]);
    cmd.push_back(n[7:0]);
    foreach (words[i]) begin
      for (int k = 3; k >= 0; k--) cmd.push_back(words[i][k*8 +: 8]);
      if (dm) begin
        exp_dw.push_back({32'(i * 4), words[i]});
        ref_dmem[i] = words[i];
      end else begin
        exp_iw.push_back({32'(i * 4), words[i]});
      end
    end
    if (dm && int'(n) > dm_hi) dm_hi = int'(n);
    exp_tx.push_back(8'hA5);
  endtask

  task automatic mk_run(input int c);
    logic [15:0] c16 = 16'(c);
    cmd.push_back(8'h03);
    cmd.push_back(c16[15:8]);
    cmd.push_back(c16[7:0]);
    exp_en = c;
    exp_tx.push_back(8'hA5);
  endtask

  task automatic mk_dump(input int n);
    logic [15:0] n16 = 16'(n);
    cmd.push_back(8'h04);
    cmd.push_back(n16[15:8]);
    cmd.push_back(n16[7:0]);
    for (int i = 0; i < n; i++)
      for (int k = 3; k >= 0; k--) exp_tx.push_back(ref_dmem[i][k*8 +: 8]);
    exp_ren = n;
    exp_tx.push_back(8'hA5);
  endtask

  task automatic mk_bad(input logic [7:0] op);
    cmd.push_back(op);
    exp_tx.push_back(8'hEE);
  endtask

  task automatic do_cmd();
    int tb0 = txq.size(), ib = iwq.size(), db = dwq.size(), eb = enq.size();
    int rb = ren_cnt, ri = ren_i, vb = viol, hb = hold_err, t = 0, en_n;
    foreach (cmd[i]) send_byte(cmd[i]);
    while ((txq.size() - tb0) < exp_tx.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check_val("tx_count", txq.size() - tb0, exp_tx.size());
    foreach (exp_tx[i]) if (tb0 + i < txq.size()) check_val("tx_byte", txq[tb0 + i], exp_tx[i]);
    check_val("busy_idle", m_busy, 0);
    check_val("imem_wr_count", iwq.size() - ib, exp_iw.size());
    foreach (exp_iw[i]) if (ib + i < iwq.size()) check_val("imem_wr", iwq[ib + i], exp_iw[i]);
    check_val("dmem_wr_count", dwq.size() - db, exp_dw.size());
    foreach (exp_dw[i]) if (db + i < dwq.size()) check_val("dmem_wr", dwq[db + i], exp_dw[i]);
    en_n = enq.size() - eb;
    check_val("enable_cycles", en_n, exp_en);
    if (en_n > 0) begin
      check_val("enable_start", enq[eb], last_acc + 1);
      check_val("enable_contig", enq[enq.size() - 1] - enq[eb], en_n - 1);
    end
    check_val("ren2_pulses", ren_cnt - rb, exp_ren);
    check_val("ren_imem", ren_i - ri, 0);
    check_val("port_while_enable", viol - vb, 0);
    check_val("tx_hold", hold_err - hb, 0);
    cmd.delete(); exp_tx.delete(); exp_iw.delete(); exp_dw.delete(); words.delete();
    exp_en = 0;
    exp_ren = 0;
  endtask

  initial begin
    logic [7:0] op;
    repeat (2) @(negedge clk);
    check_val("rst_rx_ready", m_rx_ready, 0);
    check_val("rst_busy", m_busy, 0);
    check_val("rst_tx_valid", m_tx_valid, 0);
    check_val("rst_enable", m_enable, 0);
    check_val("rst_ports", {m_wen_ext, m_wen_ext_2, m_ren_ext_2, m_addr_ext, m_addr_ext_2}, 0);
    arst_n = 1'b1;
    @(negedge clk);
    check_val("idle_rx_ready", m_rx_ready, 1);
    check_val("idle_busy", m_busy, 0);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      words = '{32'hDEADBEEF, 32'h0000002A}; mk_load(1'b0); do_cmd();
      mk_run(5); do_cmd();
      mk_run(0); do_cmd();
      words = '{32'h11223344, 32'h55667788}; mk_load(1'b1); do_cmd();
      mk_dump(2); do_cmd();
      bp = 1'b1; mk_dump(2); do_cmd(); bp = 1'b0;
      mk_bad(8'h7F); do_cmd();
      mk_load(1'b1); do_cmd();
      mk_dump(0); do_cmd();
      for (int r = 0; r < 12; r++) begin
        case ($urandom_range(0, 4))
          0: begin
            for (int i = $urandom_range(0, 4); i > 0; i--) words.push_back($urandom);
            mk_load(1'b0);
          end
          1: begin
            for (int i = $urandom_range(0, 5); i > 0; i--) words.push_back($urandom);
            mk_load(1'b1);
          end
          2: mk_run($urandom_range(0, 9));
          3: begin
            bp = 1'($urandom_range(0, 1));
            mk_dump($urandom_range(0, dm_hi));
          end
          default: begin
            op = 8'($urandom_range(0, 255));
            if (op >= 8'h01 && op <= 8'h04) op = op + 8'h10;
            mk_bad(op);
          end
        endcase
        do_cmd();
        bp = 1'b0;
      end
    end

    sel = 1'b0;
    @(negedge clk);
    begin
      int ib;
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'hDE); send_byte(8'hAD);
      ib = iwq.size();
      arst_n = 1'b0;
      #1;
      check_val("abort_rx_ready", m_rx_ready, 0);
      check_val("abort_busy", m_busy, 0);
      check_val("abort_outputs", {m_tx_valid, m_enable, m_wen_ext, m_wen_ext_2, m_ren_ext_2}, 0);
      check_val("abort_addr_data", {m_addr_ext, m_wdata_ext}, 0);
      check_val("abort_addr2_data2", {m_addr_ext_2, m_wdata_ext_2}, 0);
      @(negedge clk);
      arst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_val("abort_no_write", iwq.size() - ib, 0);
      check_val("abort_rx_ready_back", m_rx_ready, 1);
      words = '{32'hCAFEF00D, 32'h12345678}; mk_load(1'b0); do_cmd();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
